vend_dispense_ctrl: RTL and testbench

Transaction sequencer for the vending machine datapath. It accumulates coin credit and, once the price is reached, drives the product-motor handshake. It then pays change coin-by-coin through the nickel/dime hopper handshake, and refunds the full credit if the product motor never completes. It sits between the coin acceptor, the product motor driver and the change hoppers.

---
 rtl/vend_dispense_ctrl.sv | 130 +++++++++++++
 tb/tb_vend_dispense_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/vend_dispense_ctrl.sv
// Vending transaction sequencer: collects coin credit, runs the product-motor
// handshake, then pays change (or a full refund) one coin at a time.
module vend_dispense_ctrl #(
    parameter int PRICE    = 20,
    parameter int CREDIT_W = 7,
    parameter int TIMEOUT  = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                nickel,
    input  logic                dime,
    input  logic                quarter,
    output logic                coin_accept_en,
    output logic                vend_req,
    input  logic                vend_done,
    output logic                coin_out_req,
    output logic                coin_out_sel,
    input  logic                coin_out_ack,
    input  logic                dime_empty,
    output logic [CREDIT_W-1:0] credit,
    output logic                vend_fail,
    output logic                fault,
    output logic [2:0]          dbg_state
);

    localparam logic [2:0] S_ACCEPT   = 3'd0;
    localparam logic [2:0] S_VEND     = 3'd1;
    localparam logic [2:0] S_CHANGE   = 3'd2;
    localparam logic [2:0] S_WAIT_ACK = 3'd3;
    localparam logic [2:0] S_HALT     = 3'd4;

    localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] NICKEL_V  = CREDIT_W'(5);
    localparam logic [CREDIT_W-1:0] DIME_V    = CREDIT_W'(10);
    localparam logic [CREDIT_W-1:0] QUARTER_V = CREDIT_W'(25);
    localparam logic [7:0]          TMO_LAST  = 8'(TIMEOUT - 1);

    logic [2:0]          state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [7:0]          timer_q, timer_d;
    logic                sel_q, sel_d;
    logic                fail_q, fail_d;
    logic [CREDIT_W-1:0] coin_val;

    // Only a single coin pulse is a valid insertion; any combination is dropped.
    always_comb begin
        case ({nickel, dime, quarter})
            3'b100:  coin_val = NICKEL_V;
            3'b010:  coin_val = DIME_V;
            3'b001:  coin_val = QUARTER_V;
            default: coin_val = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        sel_d    = sel_q;
        fail_d   = 1'b0;
        case (state_q)
            S_ACCEPT: begin
                credit_d = credit_q + coin_val;
                if (credit_q >= PRICE_C) state_d = S_VEND;
            end
            S_VEND: begin
                if (vend_done) begin
                    credit_d = credit_q - PRICE_C;
                    state_d  = S_CHANGE;
                end else if (timer_q == TMO_LAST) begin
                    fail_d  = 1'b1;
                    state_d = S_CHANGE;
                end
            end
            S_CHANGE: begin
                if (credit_q == '0) begin
                    state_d = S_ACCEPT;
                end else if (credit_q >= DIME_V && !dime_empty) begin
                    sel_d   = 1'b1;
                    state_d = S_WAIT_ACK;
                end else begin
                    sel_d   = 1'b0;
                    state_d = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (coin_out_ack) begin
                    credit_d = credit_q - (sel_q ? DIME_V : NICKEL_V);
                    state_d  = S_CHANGE;
                end else if (timer_q == TMO_LAST) begin
                    state_d = S_HALT;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_ACCEPT;
        endcase
    end

    // Timer restarts on every state entry and only runs while a handshake waits.
    always_comb begin
        timer_d = '0;
        if (state_d == state_q && (state_q == S_VEND || state_q == S_WAIT_ACK))
            timer_d = timer_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_ACCEPT;
            credit_q <= '0;
            timer_q  <= '0;
            sel_q    <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            timer_q  <= timer_d;
            sel_q    <= sel_d;
            fail_q   <= fail_d;
        end
    end

    assign coin_accept_en = (state_q == S_ACCEPT);
    assign vend_req       = (state_q == S_VEND);
    assign coin_out_req   = (state_q == S_WAIT_ACK);
    assign coin_out_sel   = sel_q;
    assign credit         = credit_q;
    assign vend_fail      = fail_q;
    assign fault          = (state_q == S_HALT);
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Directed bench for vend_dispense_ctrl: a vector table for the coin/vend path
// plus hand-written sequences for change payout, timeouts and reset.
module tb_vend_dispense_ctrl;

    localparam logic [2:0] ST_ACCEPT = 3'd0;
    localparam logic [2:0] ST_VEND   = 3'd1;
    localparam logic [2:0] ST_CHANGE = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_HALT   = 3'd4;

    logic       clk = 1'b0;
    logic       rst, nickel, dime, quarter, vend_done, coin_out_ack, dime_empty;
    logic       coin_accept_en, vend_req, coin_out_req, coin_out_sel, vend_fail, fault;
    logic [6:0] credit;
    logic [2:0] dbg_state;

    int tests = 0;
    int fails = 0;
    logic saw_creq;

    typedef struct {
        logic       n, d, q, vd;
        logic [6:0] credit;
        logic [2:0] state;
        logic       en, vreq;
    } vec_t;
    vec_t tbl[12];

    vend_dispense_ctrl #(.PRICE(20), .CREDIT_W(7), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .nickel(nickel), .dime(dime), .quarter(quarter),
        .coin_accept_en(coin_accept_en), .vend_req(vend_req), .vend_done(vend_done),
        .coin_out_req(coin_out_req), .coin_out_sel(coin_out_sel),
        .coin_out_ack(coin_out_ack), .dime_empty(dime_empty), .credit(credit),
        .vend_fail(vend_fail), .fault(fault), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive inputs at negedge, sample 1 time unit after posedge.
    task automatic step(input logic n, input logic d, input logic q,
                        input logic vd, input logic ack, input logic r);
        @(negedge clk);
        nickel = n; dime = d; quarter = q;
        vend_done = vd; coin_out_ack = ack; rst = r;
        @(posedge clk);
        #1;
        if (coin_out_req) saw_creq = 1'b1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        saw_creq = 1'b0;
    endtask

    // Called with the DUT in CHANGE: expect a request, ack it 2 cycles later.
    task automatic pay_coin(input string name, input logic exp_sel, input logic [6:0] exp_credit);
        idle();
        chk({name, "_req"}, 32'(coin_out_req), 32'd1);
        chk({name, "_sel"}, 32'(coin_out_sel), 32'(exp_sel));
        idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk({name, "_credit"}, 32'(credit), 32'(exp_credit));
        chk({name, "_state"}, 32'(dbg_state), 32'(ST_CHANGE));
        chk({name, "_req_low"}, 32'(coin_out_req), 32'd0);
    endtask

    initial begin
        rst = 1'b1; nickel = 1'b0; dime = 1'b0; quarter = 1'b0;
        vend_done = 1'b0; coin_out_ack = 1'b0; dime_empty = 1'b0; saw_creq = 1'b0;

        //            n     d     q     vd    credit state      en    vreq
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 7'd5,  ST_ACCEPT, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 7'd5,  ST_ACCEPT, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 7'd5,  ST_ACCEPT, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 7'd5,  ST_ACCEPT, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 7'd15, ST_ACCEPT, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 7'd15, ST_ACCEPT, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 7'd20, ST_ACCEPT, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 7'd20, ST_VEND,   1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 7'd20, ST_VEND,   1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 7'd0,  ST_CHANGE, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 7'd0,  ST_ACCEPT, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 7'd0,  ST_ACCEPT, 1'b1, 1'b0};

        do_reset();
        chk("rst_credit", 32'(credit), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(ST_ACCEPT));
        chk("rst_accept_en", 32'(coin_accept_en), 32'd1);
        chk("rst_outs", {26'd0, vend_req, coin_out_req, coin_out_sel, vend_fail, fault, 1'b0}, 32'd0);

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].n, tbl[i].d, tbl[i].q, tbl[i].vd, 1'b0, 1'b0);
            chk($sformatf("vec%0d_credit", i), 32'(credit), 32'(tbl[i].credit));
            chk($sformatf("vec%0d_state", i), 32'(dbg_state), 32'(tbl[i].state));
            chk($sformatf("vec%0d_en", i), 32'(coin_accept_en), 32'(tbl[i].en));
            chk($sformatf("vec%0d_vreq", i), 32'(vend_req), 32'(tbl[i].vreq));
        end

        // Exact pay: dime, dime, vend_done 3 cycles after vend_req rises.
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("exact_c10", 32'(credit), 32'd10);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("exact_c20", 32'(credit), 32'd20);
        idle();
        chk("exact_vreq", 32'(vend_req), 32'd1);
        idle();
        idle();
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("exact_c0", 32'(credit), 32'd0);
        chk("exact_vreq_drop", 32'(vend_req), 32'd0);
        idle();
        chk("exact_state", 32'(dbg_state), 32'(ST_ACCEPT));
        chk("exact_en", 32'(coin_accept_en), 32'd1);
        chk("exact_no_creq", 32'(saw_creq), 32'd0);

        // Overpay 35: change 15 paid as dime then nickel.
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("over_c35", 32'(credit), 32'd35);
        idle();
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("over_c15", 32'(credit), 32'd15);
        pay_coin("over_dime", 1'b1, 7'd5);
        pay_coin("over_nickel", 1'b0, 7'd0);
        idle();
        chk("over_state", 32'(dbg_state), 32'(ST_ACCEPT));

        // Dime hopper empty: 15 cents change as three nickels.
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        dime_empty = 1'b1;
        pay_coin("empty_n1", 1'b0, 7'd10);
        pay_coin("empty_n2", 1'b0, 7'd5);
        pay_coin("empty_n3", 1'b0, 7'd0);
        dime_empty = 1'b0;
        idle();
        chk("empty_state", 32'(dbg_state), 32'(ST_ACCEPT));

        // Vend timeout: credit 25, no vend_done, refund dime/dime/nickel.
        do_reset();
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        chk("vto_enter", 32'(vend_req), 32'd1);
        for (int i = 0; i < 14; i++) idle();
        chk("vto_still_req", 32'(vend_req), 32'd1);
        chk("vto_no_fail_yet", 32'(vend_fail), 32'd0);
        idle();
        chk("vto_req_drop", 32'(vend_req), 32'd0);
        chk("vto_fail", 32'(vend_fail), 32'd1);
        chk("vto_credit", 32'(credit), 32'd25);
        pay_coin("vto_d1", 1'b1, 7'd15);
        chk("vto_fail_pulse", 32'(vend_fail), 32'd0);
        pay_coin("vto_d2", 1'b1, 7'd5);
        pay_coin("vto_n", 1'b0, 7'd0);
        idle();
        chk("vto_state", 32'(dbg_state), 32'(ST_ACCEPT));

        // Hopper timeout: no ack -> HALT, coins ignored, rst recovers.
        do_reset();
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("hto_c5", 32'(credit), 32'd5);
        idle();
        chk("hto_req", 32'(coin_out_req), 32'd1);
        for (int i = 0; i < 14; i++) idle();
        chk("hto_still_req", 32'(coin_out_req), 32'd1);
        chk("hto_no_fault_yet", 32'(fault), 32'd0);
        idle();
        chk("hto_fault", 32'(fault), 32'd1);
        chk("hto_req_low", 32'(coin_out_req), 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("hto_coin_ignored", 32'(credit), 32'd5);
        chk("hto_en", 32'(coin_accept_en), 32'd0);
        chk("hto_sticky", 32'(fault), 32'd1);
        do_reset();
        chk("hto_rst_fault", 32'(fault), 32'd0);
        chk("hto_rst_credit", 32'(credit), 32'd0);
        chk("hto_rst_state", 32'(dbg_state), 32'(ST_ACCEPT));

        // Reset in the middle of WAIT_ACK.
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        chk("mid_req", 32'(coin_out_req), 32'd1);
        do_reset();
        chk("mid_req_low", 32'(coin_out_req), 32'd0);
        chk("mid_credit", 32'(credit), 32'd0);
        chk("mid_state", 32'(dbg_state), 32'(ST_ACCEPT));
        chk("mid_en", 32'(coin_accept_en), 32'd1);
        chk("mid_outs", {27'd0, vend_req, coin_out_sel, vend_fail, fault, 1'b0}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
